encore_fifo_unpacker: RTL
=========================

// Module: encore_fifo_unpacker
// PURPOSE
//  Drains the 128-bit command FIFO that the AXI slave front-end fills, and serializes each entry into WORD_W-bit words on a valid/ready stream toward the core.
//  Draining is armed by the run pulse (turn2run). Running counters are exported as a 128-bit status word that wires back to the front-end's syn_reg1 readback.
//  The FIFO read side is in this block's clock domain.
// PARAMETERS
//  DATA_W      128  FIFO entry width; must be an integer multiple of WORD_W
//  WORD_W      32   output word width; LANES = DATA_W/WORD_W (default 4)
//  RD_LATENCY  1    cycles from fifo_rd_en to valid fifo_rd_data (1..3)
//  CNT_W       32   status counter width (counters wrap modulo 2^CNT_W)
// PORTS
//  s_axi_aclk     in   1       clock
//  s_axi_aresetn  in   1       asynchronous active-low reset
//  fifo_empty     in   1       FIFO empty flag
//  fifo_rd_data   in   DATA_W  FIFO read data, valid RD_LATENCY cycles after rd_en
//  fifo_rd_en     out  1       FIFO read strobe, single-cycle pulses only
//  run_start      in   1       turn2run pulse (multi-cycle high), rising-edge detected
//  m_valid        out  1       output word valid
//  m_data         out  WORD_W  output word
//  m_last         out  1       marks the final emitted word of an entry
//  m_ready        in   1       consumer ready
//  busy           out  1       high whenever state != IDLE or running
//  status         out  128     {28'b0, running, state[2:0], skip_cnt, word_cnt, entry_cnt}
// BEHAVIOUR
//  - Reset (async assert, sync deassert on s_axi_aclk):
//    - state=IDLE, running=0, all counters=0.
//    - fifo_rd_en, m_valid, m_last, busy = 0; m_data = 0; status = 0.
//  - run_start edge: a registered copy is compared each cycle; a 0->1 transition sets running.
//    - A pulse held 3 cycles arms exactly once.
//    - An edge while already running is ignored (no-op).
//  - FSM states:
//    - IDLE:
//      - running & !fifo_empty -> FETCH.
//      - running & fifo_empty -> clear running, stay IDLE (drain complete).
//    - FETCH: fifo_rd_en=1 for exactly this cycle -> WAIT.
//    - WAIT: count RD_LATENCY cycles, then capture fifo_rd_data into the entry buffer and build lane_mask -> EMIT.
//      - lane_mask is all-ones without the macro.
//      - If lane_mask==0: entry_cnt++ and go straight to IDLE.
//    - EMIT: present the lowest set lane of lane_mask (lane 0 = bits[WORD_W-1:0] first) on m_data, with m_valid=1.
//      - m_last=1 when it is the last set lane.
//      - On m_valid&m_ready: clear that lane bit and word_cnt++.
//      - On the last lane: entry_cnt++ and go to IDLE.
//  - Outputs are registered. While m_valid=1 & m_ready=0, m_data and m_last hold stable. m_valid never drops without a handshake.
//  - Throughput: a word per cycle in EMIT when m_ready=1. Per entry: 1 IDLE + 1 FETCH + RD_LATENCY + LANES cycles minimum.
//  - fifo_rd_en is never asserted when fifo_empty=1, and never asserted while an entry is buffered (at most one entry held).
//  - run_start edge in the same cycle IDLE sees fifo_empty: running is set; the clear happens next IDLE cycle, whichever is later.
//  - Reset mid-EMIT/WAIT: the buffered entry is dropped (not re-read) and counters are cleared.
//  - status: a registered copy of the counters, state and running, updated every cycle. skip_cnt is 0 without the macro.
// CONFIGURATION
//  ENCORE_UNPACK_SKIP_ZERO_EN defined:
//   - A lane whose WORD_W bits are all zero is cleared from lane_mask at capture.
//   - skip_cnt advances by the number of zero lanes.
//   - m_last marks the last nonzero lane.
//   - An all-zero entry emits nothing but still increments entry_cnt.
//  Undefined:
//   - All LANES words are emitted; lane_mask is all-ones.
//   - skip_cnt is tied to 0 and the zero-detect logic is absent.
// STRUCTURE
//  Shared package encore_pkg:
//   - FSM state encoding (IDLE=0, FETCH=1, WAIT=2, EMIT=3).
//   - STATUS_*_LSB bit offsets.
//   - LANES localparam function.
//  Sub-module encore_unpack_lane_sel (combinational):
//   - Inputs: lane_mask.
//   - Outputs: lowest-set-lane index, is_last flag, and the zero-lane mask (under the macro).
//   - Instantiated once.
// TESTING
//  T1 basic: 1 entry 128'h4444_4444_3333_3333_2222_2222_1111_1111, then run_start high 3 cycles, m_ready=1
//     -> words 1111_1111, 2222_2222, 3333_3333, 4444_4444 on consecutive cycles; m_last on the 4th;
//     -> entry_cnt=1, word_cnt=4; running=0 after the FIFO drains.
//  T2 backpressure: m_ready toggles 1,0,0,1,...
//     -> m_data/m_last stable across stalls; no word lost or duplicated; exactly one fifo_rd_en per entry.
//  T3 no run: 3 entries loaded, run_start never pulsed
//     -> fifo_rd_en stays 0, m_valid stays 0, status=0.
//  T4 multi-entry/edge: 3 entries, run_start pulsed twice while draining
//     -> 12 words in order, entry_cnt=3, second pulse ignored.
//     -> Then pulse again with FIFO empty: fifo_rd_en stays 0 and running clears.
//  T5 reset: assert s_axi_aresetn=0 mid-EMIT after 2 words
//     -> all outputs and counters 0 immediately (async).
//     -> After release plus a new pulse: the next FIFO entry starts at lane 0.
//  T6 macro on: entry 128'h0000_0000_AAAA_AAAA_0000_0000_5555_5555
//     -> words 5555_5555, then AAAA_AAAA with m_last; skip_cnt=2.
//     -> An all-zero entry gives entry_cnt+1 and no m_valid.

Source files
------------

// File: rtl/encore_pkg.sv
// rtl/encore_pkg.sv - shared FSM encoding, status layout and lane helpers for the FIFO unpacker
package encore_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_EMIT  = 2'd3
    } state_t;

    localparam int STATUS_W         = 128;
    localparam int STATUS_ENTRY_LSB = 0;
    localparam int STATUS_WORD_LSB  = 32;
    localparam int STATUS_SKIP_LSB  = 64;
    localparam int STATUS_STATE_LSB = 96;
    localparam int STATUS_RUN_LSB   = 99;

    function automatic int lanes_of(input int data_w, input int word_w);
        return data_w / word_w;
    endfunction

    function automatic int idx_w_of(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/encore_fifo_unpacker_if.sv
// rtl/encore_fifo_unpacker_if.sv - FIFO read port and word stream bundle between unpacker and its neighbours
interface encore_fifo_unpacker_if #(
    parameter int DATA_W = 128,
    parameter int WORD_W = 32
);
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_rd_en;
    logic              m_valid;
    logic [WORD_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;

    modport master (
        input  fifo_empty, fifo_rd_data, m_ready,
        output fifo_rd_en, m_valid, m_data, m_last
    );

    modport slave (
        output fifo_empty, fifo_rd_data, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_last
    );
endinterface

// File: rtl/encore_unpack_lane_sel.sv
// rtl/encore_unpack_lane_sel.sv - lowest-set-lane picker; zero-lane detect under ENCORE_UNPACK_SKIP_ZERO_EN
module encore_unpack_lane_sel
    import encore_pkg::*;
#(
    parameter int  DATA_W = 128,
    parameter int  WORD_W = 32,
    localparam int LANES  = lanes_of(DATA_W, WORD_W),
    localparam int IDX_W  = idx_w_of(LANES)
) (
    input  logic [LANES-1:0]  lane_mask,
`ifdef ENCORE_UNPACK_SKIP_ZERO_EN
    input  logic [DATA_W-1:0] data,
    output logic [LANES-1:0]  zero_lanes,
`endif
    output logic [IDX_W-1:0]  lane_idx,
    output logic              is_last
);

    logic found;

    always_comb begin
        lane_idx = '0;
        found    = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (!found && lane_mask[i]) begin
                lane_idx = IDX_W'(i);
                found    = 1'b1;
            end
        end
    end

    // Last lane when clearing the lowest set bit leaves nothing behind.
    assign is_last = ((lane_mask & (lane_mask - LANES'(1))) == '0);

`ifdef ENCORE_UNPACK_SKIP_ZERO_EN
    always_comb begin
        zero_lanes = '0;
        for (int i = 0; i < LANES; i++) begin
            zero_lanes[i] = (data[i*WORD_W +: WORD_W] == '0);
        end
    end
`endif

endmodule

// File: rtl/encore_fifo_unpacker.sv
// rtl/encore_fifo_unpacker.sv - command FIFO drain and word serializer; ENCORE_UNPACK_SKIP_ZERO_EN drops zero lanes
module encore_fifo_unpacker
    import encore_pkg::*;
#(
    parameter int DATA_W     = 128,
    parameter int WORD_W     = 32,
    parameter int RD_LATENCY = 1,
    parameter int CNT_W      = 32
) (
    input  logic                   s_axi_aclk,
    input  logic                   s_axi_aresetn,
    input  logic                   run_start,
    output logic                   busy,
    output logic [STATUS_W-1:0]    status,
    encore_fifo_unpacker_if.master bus
);

    localparam int LANES  = lanes_of(DATA_W, WORD_W);
    localparam int IDX_W  = idx_w_of(LANES);
    localparam int WAIT_W = 2;

    state_t            state, state_d;
    logic              running, running_d, run_q, run_rise;
    logic [WAIT_W-1:0] wait_cnt, wait_d;
    logic [DATA_W-1:0] entry_buf, buf_d;
    logic [LANES-1:0]  lane_mask, mask_d, capture_mask;
    logic [CNT_W-1:0]  entry_cnt, entry_d, word_cnt, word_d, skip_cnt, skip_d, skip_inc;
    logic              rd_en_d, valid_d, last_d, sel_last;
    logic [WORD_W-1:0] data_d;
    logic [IDX_W-1:0]  sel_idx;
    logic [STATUS_W-1:0] status_d;

`ifdef ENCORE_UNPACK_SKIP_ZERO_EN
    logic [LANES-1:0] zero_lanes;
    assign capture_mask = ~zero_lanes;
    assign skip_inc     = CNT_W'($countones(zero_lanes));
`else
    assign capture_mask = '1;
    assign skip_inc     = '0;
`endif

    assign run_rise = run_start & ~run_q;
    assign busy     = (state != ST_IDLE) || running;

    always_comb begin
        state_d   = state;
        running_d = running;
        wait_d    = wait_cnt;
        buf_d     = entry_buf;
        mask_d    = lane_mask;
        entry_d   = entry_cnt;
        word_d    = word_cnt;
        skip_d    = skip_cnt;
        rd_en_d   = 1'b0;
        if (run_rise && !running) begin
            running_d = 1'b1;
        end
        case (state)
            ST_IDLE: begin
                if (running && !bus.fifo_empty) begin
                    state_d = ST_FETCH;
                    rd_en_d = 1'b1;
                end else if (running) begin
                    running_d = 1'b0;
                end
            end
            ST_FETCH: begin
                state_d = ST_WAIT;
                wait_d  = '0;
            end
            ST_WAIT: begin
                if (wait_cnt == WAIT_W'(RD_LATENCY - 1)) begin
                    buf_d  = bus.fifo_rd_data;
                    mask_d = capture_mask;
                    skip_d = skip_cnt + skip_inc;
                    if (capture_mask == '0) begin
                        entry_d = entry_cnt + CNT_W'(1);
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_EMIT;
                    end
                end else begin
                    wait_d = wait_cnt + WAIT_W'(1);
                end
            end
            ST_EMIT: begin
                if (bus.m_valid && bus.m_ready) begin
                    word_d = word_cnt + CNT_W'(1);
                    mask_d = lane_mask & (lane_mask - LANES'(1));
                    if (bus.m_last) begin
                        entry_d = entry_cnt + CNT_W'(1);
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Lane select runs on the next-cycle mask so the word leaves a register.
    encore_unpack_lane_sel #(
        .DATA_W (DATA_W),
        .WORD_W (WORD_W)
    ) u_lane_sel (
        .lane_mask  (mask_d),
`ifdef ENCORE_UNPACK_SKIP_ZERO_EN
        .data       (bus.fifo_rd_data),
        .zero_lanes (zero_lanes),
`endif
        .lane_idx   (sel_idx),
        .is_last    (sel_last)
    );

    assign valid_d = (state_d == ST_EMIT);
    assign data_d  = valid_d ? buf_d[int'(sel_idx)*WORD_W +: WORD_W] : '0;
    assign last_d  = valid_d & sel_last;

    always_comb begin
        status_d = '0;
        status_d[STATUS_ENTRY_LSB +: CNT_W] = entry_cnt;
        status_d[STATUS_WORD_LSB  +: CNT_W] = word_cnt;
        status_d[STATUS_SKIP_LSB  +: CNT_W] = skip_cnt;
        status_d[STATUS_STATE_LSB +: 3]     = {1'b0, state};
        status_d[STATUS_RUN_LSB]            = running;
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state          <= ST_IDLE;
            running        <= 1'b0;
            run_q          <= 1'b0;
            wait_cnt       <= '0;
            entry_buf      <= '0;
            lane_mask      <= '0;
            entry_cnt      <= '0;
            word_cnt       <= '0;
            skip_cnt       <= '0;
            bus.fifo_rd_en <= 1'b0;
            bus.m_valid    <= 1'b0;
            bus.m_data     <= '0;
            bus.m_last     <= 1'b0;
            status         <= '0;
        end else begin
            state          <= state_d;
            running        <= running_d;
            run_q          <= run_start;
            wait_cnt       <= wait_d;
            entry_buf      <= buf_d;
            lane_mask      <= mask_d;
            entry_cnt      <= entry_d;
            word_cnt       <= word_d;
            skip_cnt       <= skip_d;
            bus.fifo_rd_en <= rd_en_d;
            bus.m_valid    <= valid_d;
            bus.m_data     <= data_d;
            bus.m_last     <= last_d;
            status         <= status_d;
        end
    end

endmodule
